// File: rtl/sound_sequencer_pkg.sv
// ============================================================================
// Module : sound_sequencer_pkg
// Brief  : Effect codes, sequencer state encoding and counter widths.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sound_sequencer_pkg;

    localparam int DUR_W  = 20;
    localparam int HALF_W = 14;

    localparam logic [1:0] SND_NONE   = 2'd0;
    localparam logic [1:0] SND_BOUNCE = 2'd1;
    localparam logic [1:0] SND_WALL   = 2'd2;
    localparam logic [1:0] SND_SPEED  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_t;

    function automatic logic has_second_note(input logic [1:0] code);
        return (code == SND_WALL) || (code == SND_SPEED);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sound_sequencer_square_osc.sv
// ============================================================================
// Module : square_osc
// Brief  : Square-wave phase generator with restart; wave is the phase for the
//          coming cycle so the caller can register it without extra latency.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module square_osc
    import sound_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic              restart,
    input  logic [HALF_W-1:0] half_period,
    output logic              wave
);

    localparam logic [HALF_W-1:0] C_ONE = HALF_W'(1);

    logic              phase;
    logic [HALF_W-1:0] half_cnt;
    logic              at_limit;

    assign at_limit = (half_cnt == (half_period - C_ONE));

    always_comb begin
        wave = phase;
        if (restart) begin
            wave = 1'b1;
        end else if (en && at_limit) begin
            wave = ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            phase    <= 1'b0;
            half_cnt <= '0;
        end else begin
            phase <= wave;
            if (restart) begin
                half_cnt <= '0;
            end else if (en) begin
                half_cnt <= at_limit ? '0 : half_cnt + C_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sound_sequencer.sv
// ============================================================================
// Module : sound_sequencer
// Brief  : Plays short fixed note patterns on a 1-bit square-wave pin in
//          response to effect codes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sound_sequencer
    import sound_sequencer_pkg::*;
#(
    parameter int HALF_P1  = 13636,
    parameter int HALF_P2  = 9091,
    parameter int HALF_P3  = 6818,
    parameter int NOTE_CYC = 720000,
    parameter int GAP_CYC  = 240000
)(
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] code_sound,
    input  logic       mute,
    output logic       sound,
    output logic       busy
);

    localparam logic [DUR_W-1:0]  C_NOTE_LAST = DUR_W'(NOTE_CYC - 1);
    localparam logic [DUR_W-1:0]  C_GAP_LAST  = DUR_W'(GAP_CYC - 1);
    localparam logic [DUR_W-1:0]  C_DUR_ONE   = DUR_W'(1);
    localparam logic [HALF_W-1:0] C_HALF_1    = HALF_W'(HALF_P1);
    localparam logic [HALF_W-1:0] C_HALF_2    = HALF_W'(HALF_P2);
    localparam logic [HALF_W-1:0] C_HALF_3    = HALF_W'(HALF_P3);

    seq_state_t        state;
    logic [1:0]        code_q;
    logic [1:0]        pattern;
    logic              note_idx;
    logic [DUR_W-1:0]  dur_cnt;
    logic [HALF_W-1:0] half_period;
    logic              trigger;
    logic              dur_done;
    logic              osc_restart;
    logic              osc_en;
    logic              wave;

    assign trigger     = (code_sound != SND_NONE) && (code_sound != code_q);
    assign dur_done    = (state == ST_NOTE) ? (dur_cnt == C_NOTE_LAST)
                                            : (dur_cnt == C_GAP_LAST);
    assign osc_restart = trigger || ((state == ST_GAP) && dur_done);
    assign osc_en      = (state == ST_NOTE);

    always_comb begin
        half_period = C_HALF_1;
        case (pattern)
            SND_WALL:  half_period = C_HALF_2;
            SND_SPEED: half_period = note_idx ? C_HALF_3 : C_HALF_1;
            default:   half_period = C_HALF_1;
        endcase
    end

    square_osc u_osc (
        .clk         (clk),
        .clr         (clr),
        .en          (osc_en),
        .restart     (osc_restart),
        .half_period (half_period),
        .wave        (wave)
    );

    // A new trigger always wins, even mid-pattern: restart from note 0, no gap.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            code_q   <= SND_NONE;
            pattern  <= SND_NONE;
            note_idx <= 1'b0;
            dur_cnt  <= '0;
            sound    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            code_q <= code_sound;
            if (trigger) begin
                state    <= ST_NOTE;
                pattern  <= code_sound;
                note_idx <= 1'b0;
                dur_cnt  <= '0;
                sound    <= wave & ~mute;
                busy     <= 1'b1;
            end else begin
                case (state)
                    ST_NOTE: begin
                        if (dur_done) begin
                            dur_cnt <= '0;
                            sound   <= 1'b0;
                            if (has_second_note(pattern) && !note_idx) begin
                                state <= ST_GAP;
                                busy  <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            dur_cnt <= dur_cnt + C_DUR_ONE;
                            sound   <= wave & ~mute;
                            busy    <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        busy <= 1'b1;
                        if (dur_done) begin
                            state    <= ST_NOTE;
                            note_idx <= 1'b1;
                            dur_cnt  <= '0;
                            sound    <= wave & ~mute;
                        end else begin
                            dur_cnt <= dur_cnt + C_DUR_ONE;
                            sound   <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        dur_cnt <= '0;
                        sound   <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sound_sequencer.sv
// ============================================================================
// Module : tb_sound_sequencer
// Brief  : Self-checking bench for sound_sequencer with reduced note timing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sound_sequencer;

    localparam int HP1  = 4;
    localparam int HP2  = 6;
    localparam int HP3  = 3;
    localparam int NOTE = 40;
    localparam int GAP  = 10;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [1:0] code_sound = 2'd0;
    logic       mute = 1'b0;
    logic       sound;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: time since pattern start, pattern code, last code seen.
    int         m_active = 0;
    int         m_pat = 0;
    int         m_t = 0;
    logic [1:0] m_prev = 2'd0;
    logic       m_sound = 1'b0;
    logic       m_busy = 1'b0;

    typedef struct {
        logic       clr;
        logic [1:0] code;
        logic       mute;
        logic       exp_sound;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[16];

    always #5 clk = ~clk;

    sound_sequencer #(
        .HALF_P1  (HP1),
        .HALF_P2  (HP2),
        .HALF_P3  (HP3),
        .NOTE_CYC (NOTE),
        .GAP_CYC  (GAP)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .code_sound (code_sound),
        .mute       (mute),
        .sound      (sound),
        .busy       (busy)
    );

    function automatic int pat_total(input int p);
        return (p == 1) ? NOTE : (2 * NOTE + GAP);
    endfunction

    function automatic int pat_half(input int p, input int idx);
        if (p == 2) return HP2;
        if (p == 3 && idx == 1) return HP3;
        return HP1;
    endfunction

    task automatic model_update(input logic c, input logic [1:0] cd, input logic m);
        if (c) begin
            m_active = 0;
            m_prev   = 2'd0;
        end else begin
            if (cd != 2'd0 && cd != m_prev) begin
                m_active = 1;
                m_pat    = int'(cd);
                m_t      = 0;
            end else if (m_active != 0) begin
                m_t = m_t + 1;
                if (m_t >= pat_total(m_pat)) m_active = 0;
            end
            m_prev = cd;
        end
        m_busy  = (m_active != 0);
        m_sound = 1'b0;
        if (m_active != 0 && !m) begin
            if (m_t < NOTE)
                m_sound = ((m_t / pat_half(m_pat, 0)) % 2) == 0;
            else if (m_t >= NOTE + GAP)
                m_sound = (((m_t - NOTE - GAP) / pat_half(m_pat, 1)) % 2) == 0;
        end
    endtask

    task automatic drive_clock(input logic c, input logic [1:0] cd, input logic m);
        clr        = c;
        code_sound = cd;
        mute       = m;
        @(posedge clk);
        #1;
        model_update(c, cd, m);
    endtask

    task automatic step(input logic c, input logic [1:0] cd, input logic m);
        drive_clock(c, cd, m);
        vectors++;
        if (sound !== m_sound || busy !== m_busy) begin
            miscompares++;
            $display("FAIL model t=%0t code=%0d mute=%0b clr=%0b: sound=%0b busy=%0b, expected sound=%0b busy=%0b",
                     $time, cd, m, c, sound, busy, m_sound, m_busy);
        end
    endtask

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) step(1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        int pulses;
        logic prev_snd;
        logic [1:0] rc;
        logic rm;
        logic rclr;

        tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 2'd2, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 2'd2, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 16; i++) begin
            drive_clock(tbl[i].clr, tbl[i].code, tbl[i].mute);
            vectors++;
            if (sound !== tbl[i].exp_sound || busy !== tbl[i].exp_busy) begin
                miscompares++;
                $display("FAIL table[%0d]: sound=%0b busy=%0b, expected sound=%0b busy=%0b",
                         i, sound, busy, tbl[i].exp_sound, tbl[i].exp_busy);
            end
        end

        // Held code 1: one 40-cycle note, five 4-cycle pulses, no retrigger.
        step(1'b1, 2'd0, 1'b0);
        busy_cnt = 0; pulses = 0; prev_snd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 2'd1, 1'b0);
            if (busy) busy_cnt++;
            if (sound && !prev_snd) pulses++;
            prev_snd = sound;
        end
        check("held_code1_busy_cycles", busy_cnt, NOTE);
        check("held_code1_pulses", pulses, 5);
        drain();

        // Code 2 pulse: note, gap, note.
        busy_cnt = 0;
        step(1'b0, 2'd2, 1'b0);
        if (busy) busy_cnt++;
        for (int i = 0; i < 110; i++) begin
            step(1'b0, 2'd0, 1'b0);
            if (busy) busy_cnt++;
        end
        check("code2_busy_cycles", busy_cnt, 2 * NOTE + GAP);

        // Code 3 interrupted by code 1 fifteen cycles later.
        busy_cnt = 0;
        step(1'b0, 2'd3, 1'b0);
        if (busy) busy_cnt++;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 2'd0, 1'b0);
            if (busy) busy_cnt++;
        end
        for (int i = 0; i < 80; i++) begin
            step(1'b0, 2'd1, 1'b0);
            if (busy) busy_cnt++;
        end
        check("abort_busy_cycles", busy_cnt, 15 + NOTE);
        drain();

        // Mute window inside a code 1 note.
        busy_cnt = 0;
        step(1'b0, 2'd1, 1'b0);
        if (busy) busy_cnt++;
        for (int i = 1; i < 60; i++) begin
            step(1'b0, 2'd1, (i >= 10 && i <= 30) ? 1'b1 : 1'b0);
            if (busy) busy_cnt++;
        end
        check("mute_busy_cycles", busy_cnt, NOTE);
        drain();

        // Reset mid-gap of pattern 2, then the held code restarts it.
        for (int i = 0; i < NOTE + 4; i++) step(1'b0, 2'd2, 1'b0);
        check("pre_clr_busy", int'(busy), 1);
        step(1'b1, 2'd2, 1'b0);
        check("clr_busy", int'(busy), 0);
        check("clr_sound", int'(sound), 0);
        step(1'b0, 2'd2, 1'b0);
        check("after_clr_busy", int'(busy), 1);
        check("after_clr_sound", int'(sound), 1);
        drain();

        // 1 -> 0 -> 1: the zero does not stop, the second 1 restarts.
        step(1'b0, 2'd1, 1'b0);
        step(1'b0, 2'd1, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        check("zero_keeps_busy", int'(busy), 1);
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 2'd1, 1'b0);
            if (busy) busy_cnt++;
        end
        check("retrigger_busy_cycles", busy_cnt, NOTE);
        drain();

        // Randomized traffic against the reference model.
        rc = 2'd0; rm = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) rc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) rm = ~rm;
            rclr = ($urandom_range(0, 299) == 0);
            step(rclr, rc, rm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
